// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between the FIFO drain stage and its neighbours: FIFO read port,
// output stream and burst framing. Member names are as seen from the reader.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8
);
  logic                  o_fifo_rd_req;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  i_fifo_valid;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  o_m_valid;
  logic                  o_m_last;
  logic                  i_m_ready;
  logic [LEN_W-1:0]      i_burst_len;
  logic [LEN_W-1:0]      o_beat_cnt;
  logic [1:0]            o_occupancy;

  modport master (
    output o_fifo_rd_req,
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_fifo_valid,
    output o_m_data,
    output o_m_valid,
    output o_m_last,
    input  i_m_ready,
    input  i_burst_len,
    output o_beat_cnt,
    output o_occupancy
  );

  modport slave (
    input  o_fifo_rd_req,
    output i_fifo_empty,
    output i_fifo_data,
    output i_fifo_valid,
    input  o_m_data,
    input  o_m_valid,
    input  o_m_last,
    output i_m_ready,
    output i_burst_len,
    input  o_beat_cnt,
    input  o_occupancy
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a latency-1 FIFO into a 2-entry skid buffer and presents the words as a
// valid/ready stream framed into bursts of runtime length, sustaining 1 beat/cycle.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  fifo_stream_reader_if.master bus
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [LEN_W-1:0]      r_len_q;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_cap;
  logic [2:0]            w_used;
  logic                  w_rd_req;
  logic [LEN_W-1:0]      w_len_in;
  logic [LEN_W-1:0]      w_len_eff;
  logic                  w_last;

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid & bus.i_m_ready & i_ena;
  assign w_cap   = i_ena & bus.i_fifo_valid;

  // Credits: held entries plus the word still in flight, minus the slot this pop frees.
  assign w_used   = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_rd_req = i_ena & ~i_rst & ~bus.i_fifo_empty &
                    (w_used < (3'd2 + {2'b00, w_pop}));

  // A new burst samples the length on its first beat; later beats use the latched copy.
  assign w_len_in  = (bus.i_burst_len == '0) ? LEN_W'(1) : bus.i_burst_len;
  assign w_len_eff = (r_beat_cnt == '0) ? w_len_in : r_len_q;
  assign w_last    = w_valid & (r_beat_cnt == (w_len_eff - LEN_W'(1)));

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: both skid entries are reset, not just the occupancy, so the head reads 0
      // out of reset instead of leaking stale data onto o_m_data.
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
      r_len_q    <= LEN_W'(1);
    end else if (i_ena) begin
      r_inflight <= w_rd_req;

      case ({w_cap, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= bus.i_fifo_data;
          else               r_tail <= bus.i_fifo_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
            r_tail <= bus.i_fifo_data;
          end else begin
            r_head <= bus.i_fifo_data;
          end
        end
        default: ;
      endcase

      if (w_pop) begin
        if (r_beat_cnt == '0) r_len_q <= w_len_in;
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + LEN_W'(1);
      end
    end
  end

  assign bus.o_fifo_rd_req = w_rd_req;
  assign bus.o_m_data      = r_head;
  assign bus.o_m_valid     = w_valid;
  assign bus.o_m_last      = w_last;
  assign bus.o_beat_cnt    = r_beat_cnt;
  assign bus.o_occupancy   = r_occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard of expected words and a
// monitor that checks every stream beat against a burst-framing reference.
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_ena (ena),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: unbounded store, one word returned the cycle after a request.
  logic [DW-1:0] mem [0:4095];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic [DW-1:0] f_data = '0;
  logic          f_valid = 1'b0;
  logic [DW-1:0] exp_q [$];

  assign bus.i_fifo_empty = (wr_cnt == rd_cnt);
  assign bus.i_fifo_data  = f_data;
  assign bus.i_fifo_valid = f_valid;

  always @(posedge clk) begin
    if (rst) begin
      f_valid <= 1'b0;
    end else if (ena) begin
      f_valid <= bus.o_fifo_rd_req;
      if (bus.o_fifo_rd_req) begin
        f_data <= mem[rd_cnt % 4096];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wr_cnt % 4096] = d;
    wr_cnt++;
    exp_q.push_back(d);
  endtask

  // Monitor: beats remaining in the current burst decide where last must fall.
  initial begin
    int            m_left = 0;
    int            m_idx  = 0;
    logic          p_hold = 1'b0;
    logic          p_frozen = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          p_last = 1'b0;
    logic          p_valid = 1'b0;
    logic [LW-1:0] p_beat = '0;
    logic [1:0]    p_occ = '0;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        m_left   = 0;
        m_idx    = 0;
        p_hold   = 1'b0;
        p_frozen = 1'b0;
      end else begin
        if (!ena) check("rdreq_while_disabled", bus.o_fifo_rd_req, 0);
        if (bus.i_fifo_empty) check("rdreq_while_empty", bus.o_fifo_rd_req, 0);
        check("occ_le_2", (bus.o_occupancy <= 2'd2), 1);
        check("valid_iff_occ", bus.o_m_valid, (bus.o_occupancy != 2'd0));
        if (p_hold) begin
          check("hold_valid", bus.o_m_valid, 1);
          check("hold_data", bus.o_m_data, p_data);
          check("hold_last", bus.o_m_last, p_last);
        end
        if (p_frozen) begin
          check("frozen_valid", bus.o_m_valid, p_valid);
          check("frozen_data", bus.o_m_data, p_data);
          check("frozen_beat", bus.o_beat_cnt, p_beat);
          check("frozen_occ", bus.o_occupancy, p_occ);
        end
        if (bus.o_m_valid && bus.i_m_ready && ena) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data 0x%0h expected no beat", bus.o_m_data);
          end else begin
            d = exp_q.pop_front();
            check("beat_data", bus.o_m_data, d);
            if (m_left == 0) m_left = (bus.i_burst_len == 0) ? 1 : int'(bus.i_burst_len);
            check("beat_last", bus.o_m_last, (m_left == 1));
            check("beat_index", bus.o_beat_cnt, m_idx);
            m_left--;
            m_idx = (m_left == 0) ? 0 : m_idx + 1;
          end
        end
        p_hold   = bus.o_m_valid & ~(bus.i_m_ready & ena);
        p_frozen = ~ena;
        p_data   = bus.o_m_data;
        p_last   = bus.o_m_last;
        p_valid  = bus.o_m_valid;
        p_beat   = bus.o_beat_cnt;
        p_occ    = bus.o_occupancy;
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.o_m_valid, 0);
    check({tag, "_data"},  bus.o_m_data, 0);
    check({tag, "_last"},  bus.o_m_last, 0);
    check({tag, "_beat"},  bus.o_beat_cnt, 0);
    check({tag, "_occ"},   bus.o_occupancy, 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.o_m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), budget);
    end
  endtask

  initial begin
    logic [DW-1:0] t3_words [3];
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic [LW-1:0] s_beat;
    logic [1:0]    s_occ;
    int            nreq;
    int            nbeat;
    int            lasts [4];
    int            idxs [4];

    rst = 1'b1;
    ena = 1'b1;
    bus.i_m_ready   = 1'b1;
    bus.i_burst_len = LW'(4);
    for (int i = 0; i < 5; i++) push(DW'(16'h00A0 + i));

    // Test 1: two reset cycles with a non-empty FIFO.
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst1");
    check("rst1_rdreq", bus.o_fifo_rd_req, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst2");
    check("first_rdreq_after_release", bus.o_fifo_rd_req, 1);

    // Test 2: five words, burst length 4, beats start two cycles after the first request.
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1 || k == 7) begin
        check("t2_valid_idle", bus.o_m_valid, 0);
      end else begin
        check("t2_valid", bus.o_m_valid, 1);
        check("t2_data", bus.o_m_data, 32'h00A0 + k - 2);
        check("t2_last", bus.o_m_last, (k == 5));
        check("t2_beat", bus.o_beat_cnt, (k - 2) % 4);
      end
    end

    // Test 3: consumer stalled for 6 cycles, then released.
    t3_words = '{16'h0011, 16'h0022, 16'h0033};
    drive_slot();
    bus.i_m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(t3_words[i]);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nreq += int'(bus.o_fifo_rd_req);
    end
    check("t3_rdreq_count", nreq, 2);
    check("t3_occ_full", bus.o_occupancy, 2);
    check("t3_head", bus.o_m_data, 16'h0011);
    drive_slot();
    bus.i_m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_b2b_valid", bus.o_m_valid, 1);
      check("t3_b2b_data", bus.o_m_data, t3_words[i]);
    end
    @(negedge clk);
    check("t3_drained", bus.o_m_valid, 0);

    // Test 4: enable dropped for three cycles mid-stream.
    drive_slot();
    for (int i = 0; i < 20; i++) push(DW'(16'h4000 + i));
    repeat (5) drive_slot();
    ena = 1'b0;
    @(negedge clk);
    s_data  = bus.o_m_data;
    s_valid = bus.o_m_valid;
    s_beat  = bus.o_beat_cnt;
    s_occ   = bus.o_occupancy;
    check("t4_midstream", s_valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(posedge clk);
        #1 ena = 1'b1;
      end
      @(negedge clk);
      check("t4_frz_data", bus.o_m_data, s_data);
      check("t4_frz_valid", bus.o_m_valid, s_valid);
      check("t4_frz_beat", bus.o_beat_cnt, s_beat);
      check("t4_frz_occ", bus.o_occupancy, s_occ);
      if (i < 2) check("t4_frz_rdreq", bus.o_fifo_rd_req, 0);
    end
    drain(100);
    check("beat0_before_t5", bus.o_beat_cnt, 0);

    // Test 5a: length 0 behaves as 1.
    drive_slot();
    bus.i_burst_len = '0;
    for (int i = 0; i < 4; i++) push(DW'(16'h5000 + i));
    nbeat = 0;
    for (int i = 0; i < 20 && nbeat < 4; i++) begin
      @(negedge clk);
      if (bus.o_m_valid) begin
        check("t5_len0_last", bus.o_m_last, 1);
        nbeat++;
      end
    end
    check("t5_len0_beats", nbeat, 4);
    drain(50);

    // Test 5b: length 3 changed to 1 after beat 0 still ends on beat 2.
    drive_slot();
    bus.i_burst_len = LW'(3);
    for (int i = 0; i < 4; i++) push(DW'(16'h5100 + i));
    nbeat = 0;
    for (int i = 0; i < 20 && nbeat < 4; i++) begin
      @(negedge clk);
      if (bus.o_m_valid) begin
        lasts[nbeat] = int'(bus.o_m_last);
        idxs[nbeat]  = int'(bus.o_beat_cnt);
        nbeat++;
        if (nbeat == 1) begin
          drive_slot();
          bus.i_burst_len = LW'(1);
        end
      end
    end
    check("t5_len3_beats", nbeat, 4);
    check("t5_last_b0", lasts[0], 0);
    check("t5_last_b1", lasts[1], 0);
    check("t5_last_b2", lasts[2], 1);
    check("t5_last_next", lasts[3], 1);
    check("t5_idx_b2", idxs[2], 2);
    check("t5_idx_next", idxs[3], 0);
    drain(50);

    // Test 6: FIFO stays empty.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t6_rdreq", bus.o_fifo_rd_req, 0);
      check("t6_valid", bus.o_m_valid, 0);
      check("t6_occ", bus.o_occupancy, 0);
    end

    // Randomised traffic: enable, backpressure, pushes and burst lengths.
    for (int c = 0; c < 800; c++) begin
      drive_slot();
      ena           = ($urandom_range(0, 9) != 0);
      bus.i_m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) push(DW'($urandom));
      if (!(bus.o_m_valid && bus.o_beat_cnt == '0) && $urandom_range(0, 7) == 0)
        bus.i_burst_len = LW'($urandom_range(0, 5));
    end
    drive_slot();
    ena           = 1'b1;
    bus.i_m_ready = 1'b1;
    drain(2000);
    check("sb_all_consumed", exp_q.size(), 0);
    check("fifo_all_read", rd_cnt, wr_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
